// File: rtl/col_accum.sv
`default_nettype none
// ============================================================================
// Module   : col_accum
// Purpose  : Per-column, per-lane signed accumulator bank fed by the
//            column-select unit. Accumulates one M-lane vector per cycle
//            into column `col`; on request, drains every column in
//            ascending order over valid/ready and clears each column as it
//            is handed off.
// Revision : 1.0 - initial release
// ============================================================================
module col_accum #(
  parameter int M       = 4,
  parameter int DW_POS  = 4,
  parameter int DW_DATA = 8,
  parameter int DW_ACC  = 20
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DW_POS-1:0]     col,
  input  logic [M*DW_DATA-1:0]  in,
  input  logic                  drain_start,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DW_POS-1:0]     out_col,
  output logic [M*DW_ACC-1:0]   out_data,
  output logic                  done
);

  localparam int c_NCOL = 2 ** DW_POS;

  typedef enum logic [0:0] {
    ST_ACC   = 1'b0,
    ST_DRAIN = 1'b1
  } state_t;

  state_t                r_state;
  logic [DW_POS-1:0]     r_dcnt;
  logic                  r_in_ready;
  logic                  r_out_valid;
  logic                  r_done;
  logic [DW_ACC-1:0]     r_acc [c_NCOL][M];

  logic [DW_ACC-1:0]     w_in_ext [M];
  logic                  w_acc_en;
  logic                  w_clr_en;
  logic [M*DW_ACC-1:0]   w_out_data;

  // Sign-extend each input lane to accumulator width.
  generate
    for (genvar gi = 0; gi < M; gi++) begin : g_lane
      assign w_in_ext[gi] = {{(DW_ACC-DW_DATA){in[gi*DW_DATA+DW_DATA-1]}},
                             in[gi*DW_DATA +: DW_DATA]};
    end
  endgenerate

  // Accumulate only while collecting; clear only on a drain handshake.
  assign w_acc_en = (r_state == ST_ACC) && in_valid;
  assign w_clr_en = (r_state == ST_DRAIN) && out_ready;

  // Accumulator bank: add on accept, zero the drained column on handshake.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int c = 0; c < c_NCOL; c++) begin
        for (int i = 0; i < M; i++) begin
          r_acc[c][i] <= '0;
        end
      end
    end else if (w_acc_en) begin
      for (int i = 0; i < M; i++) begin
        r_acc[col][i] <= r_acc[col][i] + w_in_ext[i];
      end
    end else if (w_clr_en) begin
      for (int i = 0; i < M; i++) begin
        r_acc[r_dcnt][i] <= '0;
      end
    end
  end

  // Control FSM: ACC <-> DRAIN with registered handshake/status outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_ACC;
      r_dcnt      <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_ACC: begin
          if (drain_start) begin
            r_state     <= ST_DRAIN;
            r_dcnt      <= '0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b1;
          end
        end
        ST_DRAIN: begin
          if (out_ready) begin
            if (&r_dcnt) begin
              // Last column accepted: return to collecting.
              r_state     <= ST_ACC;
              r_dcnt      <= '0;
              r_in_ready  <= 1'b1;
              r_out_valid <= 1'b0;
              r_done      <= 1'b1;
            end else begin
              r_dcnt <= r_dcnt + {{(DW_POS-1){1'b0}}, 1'b1};
            end
          end
        end
        default: begin
          r_state     <= ST_ACC;
          r_dcnt      <= '0;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  // Output column is a mux of bank registers by the drain counter;
  // forced to zero outside a drain so idle output stays quiet.
  always_comb begin
    w_out_data = '0;
    if (r_out_valid) begin
      for (int i = 0; i < M; i++) begin
        w_out_data[i*DW_ACC +: DW_ACC] = r_acc[r_dcnt][i];
      end
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_col   = r_dcnt;
  assign out_data  = w_out_data;
  assign done      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_col_accum.sv
`default_nettype none
// ============================================================================
// Module   : tb_col_accum
// Purpose  : Directed self-checking bench for col_accum.
// Revision : 1.0 - initial release
// ============================================================================
module tb_col_accum;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  col;
  logic [31:0] in;
  logic        drain_start;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_col;
  logic [79:0] out_data;
  logic        done;

  int n_checks;
  int n_fail;

  logic [79:0] exp_bank [16];

  col_accum #(.M(4), .DW_POS(4), .DW_DATA(8), .DW_ACC(20)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .col         (col),
    .in          (in),
    .drain_start (drain_start),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_col     (out_col),
    .out_data    (out_data),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point.
  task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic clear_exp();
    for (int k = 0; k < 16; k++) exp_bank[k] = '0;
  endtask

  // Feed vector v to column c for n consecutive cycles.
  task automatic acc_vec(input logic [3:0] c, input logic [31:0] v, input int n);
    @(negedge clk);
    check("acc_inrdy", {79'd0, in_ready}, 80'd1);
    in_valid = 1'b1;
    col      = c;
    in       = v;
    repeat (n) @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Drain and compare against exp_bank. Optional vector in the drain_start
  // cycle, optional in_valid held during the drain, out_ready pattern
  // indexed by cycle mod 4, and optional reset at beat rst_beat (-1 none).
  task automatic run_drain(input bit with_in, input logic [3:0] c, input logic [31:0] v,
                           input bit keep_in, input logic [3:0] rdy_pat, input int rst_beat);
    int idx;
    int cyc;
    idx = 0;
    cyc = 0;
    @(negedge clk);
    drain_start = 1'b1;
    in_valid    = with_in;
    col         = c;
    in          = v;
    @(negedge clk);
    drain_start = 1'b0;
    in_valid    = keep_in;
    col         = 4'd3;
    in          = 32'h01010101;
    while (idx < 16 && cyc < 100) begin
      check("dr_valid", {79'd0, out_valid}, 80'd1);
      check("dr_inrdy", {79'd0, in_ready}, 80'd0);
      check("dr_done",  {79'd0, done}, 80'd0);
      check("dr_col",   {76'd0, out_col}, 80'(idx));
      check("dr_data",  out_data, exp_bank[idx]);
      if (rst_beat == idx) begin
        rst = 1'b0;
        #1;
        check("rst_valid", {79'd0, out_valid}, 80'd0);
        check("rst_inrdy", {79'd0, in_ready}, 80'd1);
        check("rst_data",  out_data, 80'd0);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        repeat (3) begin
          @(negedge clk);
          check("rst_nodone", {79'd0, done}, 80'd0);
          check("rst_idle",   {79'd0, out_valid}, 80'd0);
        end
        return;
      end
      out_ready = rdy_pat[cyc % 4];
      cyc++;
      @(negedge clk);
      if (out_ready) idx++;
    end
    check("dr_beats", 80'(idx), 80'd16);
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check("end_done",  {79'd0, done}, 80'd1);
    check("end_inrdy", {79'd0, in_ready}, 80'd1);
    check("end_valid", {79'd0, out_valid}, 80'd0);
    @(negedge clk);
    check("end_done1", {79'd0, done}, 80'd0);
  endtask

  initial begin
    n_checks    = 0;
    n_fail      = 0;
    rst         = 1'b0;
    in_valid    = 1'b0;
    col         = '0;
    in          = '0;
    drain_start = 1'b0;
    out_ready   = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_inrdy0", {79'd0, in_ready}, 80'd1);
    check("rst_valid0", {79'd0, out_valid}, 80'd0);
    check("rst_col0",   {76'd0, out_col}, 80'd0);
    check("rst_data0",  out_data, 80'd0);
    check("rst_done0",  {79'd0, done}, 80'd0);
    rst = 1'b1;

    // Idle drain: all zeros.
    clear_exp();
    run_drain(1'b0, 4'd0, 32'd0, 1'b0, 4'b1111, -1);

    // Single-column accumulate.
    acc_vec(4'd0, {8'd3, 8'd2, 8'd1, 8'd4}, 2);
    acc_vec(4'd1, {8'd3, 8'd2, 8'd1, 8'd4}, 1);
    clear_exp();
    exp_bank[0] = {20'd6, 20'd4, 20'd2, 20'd8};
    exp_bank[1] = {20'd3, 20'd2, 20'd1, 20'd4};
    run_drain(1'b0, 4'd0, 32'd0, 1'b0, 4'b1111, -1);

    // Signed accumulate reaching the most negative value.
    acc_vec(4'd5, {8'd0, 8'd0, 8'd0, 8'h80}, 4096);
    clear_exp();
    exp_bank[5] = {20'd0, 20'd0, 20'd0, 20'h80000};
    run_drain(1'b0, 4'd0, 32'd0, 1'b0, 4'b1111, -1);

    // One more step wraps around.
    acc_vec(4'd5, {8'd0, 8'd0, 8'd0, 8'h80}, 4097);
    clear_exp();
    exp_bank[5] = {20'd0, 20'd0, 20'd0, 20'h7FF80};
    run_drain(1'b0, 4'd0, 32'd0, 1'b0, 4'b1111, -1);

    // Vector coincident with drain_start is included; in_valid during drain ignored.
    clear_exp();
    exp_bank[2] = {20'd1, 20'd1, 20'd1, 20'd1};
    run_drain(1'b1, 4'd2, {8'd1, 8'd1, 8'd1, 8'd1}, 1'b1, 4'b1111, -1);

    // Backpressure with nonzero data, then a clean second drain.
    acc_vec(4'd7, {8'hFF, 8'hFF, 8'hFF, 8'hFF}, 1);
    acc_vec(4'd15, {8'd127, 8'd0, 8'd0, 8'h81}, 1);
    clear_exp();
    exp_bank[7]  = {20'hFFFFF, 20'hFFFFF, 20'hFFFFF, 20'hFFFFF};
    exp_bank[15] = {20'd127, 20'd0, 20'd0, 20'hFFF81};
    run_drain(1'b0, 4'd0, 32'd0, 1'b0, 4'b1001, -1);
    clear_exp();
    run_drain(1'b0, 4'd0, 32'd0, 1'b0, 4'b1111, -1);

    // Reset during drain at beat 7, column 10 not yet emitted.
    acc_vec(4'd10, {8'd9, 8'd8, 8'd7, 8'd6}, 1);
    clear_exp();
    exp_bank[10] = {20'd9, 20'd8, 20'd7, 20'd6};
    run_drain(1'b0, 4'd0, 32'd0, 1'b0, 4'b1111, 7);
    clear_exp();
    run_drain(1'b0, 4'd0, 32'd0, 1'b0, 4'b1111, -1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
